// File: rtl/pcie_rx_pkg.sv
// Shared definitions for the PCIe receive merge: word layout, buffer depth
// and the merge FSM state encoding.
package pcie_rx_pkg;

  localparam int DATA_W   = 6;
  localparam int DEPTH    = 4;
  localparam int VC_BIT   = 5;
  localparam int DEST_BIT = 4;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

endpackage

// File: rtl/pcie_rx_fifo.sv
// First-word-fall-through FIFO with occupancy output and synchronous flush.
// The head word reads as zero whenever the FIFO is empty.
module pcie_rx_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          flush_i,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_nxt_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_wr, do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_wr = wr_en_i && (count_q < CW'(DEPTH));
  assign do_rd = rd_en_i && (count_q != '0);

  assign count_nxt_o = flush_i ? '0 : count_q + CW'(do_wr) - CW'(do_rd);
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);
  assign rd_data_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_nxt_o;
    end
  end

  // Storage carries no reset; the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/pcie_rx_merge.sv
// Merges the D0/D1 destination FIFOs round-robin into one buffer, checking
// each word's destination bit against the port it arrived on.
//   state     | meaning
//   ST_INIT   | no pops, buffer/counters/pause cleared, thresholds load on init
//   ST_IDLE   | nothing pending; pops allowed, idle_out=1
//   ST_ACTIVE | traffic in flight; pops allowed, active_out=1
//   ST_ERROR  | misrouted word seen; pops stop, buffer drains, exit by reset only
module pcie_rx_merge #(
  parameter int DATA_W          = pcie_rx_pkg::DATA_W,
  parameter int DEPTH           = pcie_rx_pkg::DEPTH,
  parameter int UMBRAL_ALTO_DEF = 3,
  parameter int UMBRAL_BAJO_DEF = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [1:0]        umbral_alto,
  input  logic [1:0]        umbral_bajo,
  input  logic [DATA_W-1:0] in0_data,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in0_empty,
  input  logic              in1_empty,
  output logic              in0_pop,
  output logic              in1_pop,
  output logic [DATA_W-1:0] out_data,
  output logic              out_empty,
  input  logic              out_pop,
  output logic              pausa_out,
  output logic              active_out,
  output logic              idle_out,
  output logic              error_out,
  output logic [4:0]        cnt0,
  output logic [4:0]        cnt1
);

  import pcie_rx_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  state_e            state_q, state_d;
  logic              rr_q;
  logic [1:0]        alto_q, bajo_q;
  logic              pausa_q, pausa_d;
  logic              active_q, idle_q, error_q;
  logic [4:0]        cnt0_q, cnt1_q;

  logic [CW-1:0]     count, count_nxt;
  logic              buf_empty, flush;
  logic              can_pop, cand0, cand1, gnt0, gnt1, gnt_any;
  logic [DATA_W-1:0] pop_word;
  logic              route_ok, misroute, wr_en;

  assign flush   = (state_q == ST_INIT);
  assign can_pop = !reset && (state_q == ST_IDLE || state_q == ST_ACTIVE)
                   && (count < CW'(DEPTH));
  assign cand0   = can_pop && !in0_empty;
  assign cand1   = can_pop && !in1_empty;
  // rr_q=0 favours D0 when both ports contend; a lone candidate always wins.
  assign gnt0    = cand0 && (!cand1 || !rr_q);
  assign gnt1    = cand1 && (!cand0 ||  rr_q);
  assign gnt_any = gnt0 || gnt1;

  assign pop_word = gnt1 ? in1_data : in0_data;
  assign route_ok = gnt1 ? pop_word[DEST_BIT] : !pop_word[DEST_BIT];
  assign misroute = gnt_any && !route_ok;
  assign wr_en    = gnt_any && route_ok;

  assign in0_pop = gnt0;
  assign in1_pop = gnt1;

  pcie_rx_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (flush),
    .wr_en_i     (wr_en),
    .wr_data_i   (pop_word),
    .rd_en_i     (out_pop),
    .rd_data_o   (out_data),
    .empty_o     (buf_empty),
    .count_o     (count),
    .count_nxt_o (count_nxt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (misroute)                     state_d = ST_ERROR;
        else if (init)                    state_d = ST_INIT;
        else if (!in0_empty || !in1_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (misroute)   state_d = ST_ERROR;
        else if (init)  state_d = ST_INIT;
        else if (in0_empty && in1_empty && count == '0) state_d = ST_IDLE;
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_INIT;
    endcase
  end

  // Set wins over clear if the thresholds are loaded inverted.
  always_comb begin
    pausa_d = pausa_q;
    if (flush)                           pausa_d = 1'b0;
    else if (count_nxt >= CW'(alto_q))   pausa_d = 1'b1;
    else if (count_nxt <= CW'(bajo_q))   pausa_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      rr_q     <= 1'b0;
      alto_q   <= 2'(UMBRAL_ALTO_DEF);
      bajo_q   <= 2'(UMBRAL_BAJO_DEF);
      pausa_q  <= 1'b0;
      active_q <= 1'b0;
      idle_q   <= 1'b0;
      error_q  <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state_q  <= state_d;
      pausa_q  <= pausa_d;
      active_q <= (state_d == ST_ACTIVE);
      idle_q   <= (state_d == ST_IDLE);
      error_q  <= (state_d == ST_ERROR);
      if (flush) begin
        rr_q   <= 1'b0;
        cnt0_q <= '0;
        cnt1_q <= '0;
        if (init) begin
          alto_q <= umbral_alto;
          bajo_q <= umbral_bajo;
        end
      end else begin
        if (gnt_any)       rr_q   <= gnt0;
        if (wr_en && gnt0) cnt0_q <= cnt0_q + 5'd1;
        if (wr_en && gnt1) cnt1_q <= cnt1_q + 5'd1;
      end
    end
  end

  assign out_empty  = buf_empty;
  assign pausa_out  = pausa_q;
  assign active_out = active_q;
  assign idle_out   = idle_q;
  assign error_out  = error_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

endmodule
